// File: rtl/peri_arb_pkg.sv
// Shared types and helpers for the peripheral bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package peri_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEADBEEF;

    // Width of a PE index; a single-PE build still needs a 1-bit id.
    function automatic int pe_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after (last_gnt+1) mod NUM_PE.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the pick is consumed.
//
// Ports:
//  req       per-PE request vector
//  last_gnt  id of the most recently served PE
//  gnt       one-hot winner (all zero when nothing requests)
//  gnt_id    binary winner id
//  gnt_vld   at least one requester present
module rr_arbiter
    import peri_arb_pkg::*;
#(
    parameter  int NUM_PE = 3,
    localparam int IDW    = pe_id_w(NUM_PE)
) (
    input  logic [NUM_PE-1:0] req,
    input  logic [IDW-1:0]    last_gnt,
    output logic [NUM_PE-1:0] gnt,
    output logic [IDW-1:0]    gnt_id,
    output logic              gnt_vld
);

    // One extra bit so last_gnt + 1 + i (at most 2*NUM_PE-1) cannot overflow
    // before the single wrap subtraction.
    logic [IDW:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            cand = {1'b0, last_gnt} + (IDW+1)'(1) + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NUM_PE)) begin
                cand = cand - (IDW+1)'(NUM_PE);
            end
            if (!gnt_vld && req[cand[IDW-1:0]]) begin
                gnt_vld              = 1'b1;
                gnt_id               = cand[IDW-1:0];
                gnt[cand[IDW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/peri_bus_arbiter.sv
// Arbitrates NUM_PE cores onto one shared peripheral bus, one access in flight.
// Latency: gnt in cycle 0, bus strobe cycle 1, o_pe_ready one cycle after bus ready (min 2).
// Backpressure: requests outside IDLE get no gnt and must be held; a dead slave times out.
//
// Ports:
//  i_clk, i_rst                 clock, synchronous active-high reset
//  i_pe_rden/wren/addr/wdata/wstrb  per-PE request, PE k at slice k
//  o_pe_gnt                     combinational accept, IDLE only
//  o_pe_ready / o_pe_rdata      completion pulse and held read data per PE
//  o_bus_*                      shared bus strobes and latched address/data/strobes
//  i_bus_rdata / i_bus_ready    slave response
//  o_timeout                    pulses with o_pe_ready when the access was forced
module peri_bus_arbiter
    import peri_arb_pkg::*;
#(
    parameter int          NUM_PE      = 3,
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_PE-1:0]      i_pe_rden,
    input  logic [NUM_PE-1:0]      i_pe_wren,
    input  logic [NUM_PE*32-1:0]   i_pe_addr,
    input  logic [NUM_PE*32-1:0]   i_pe_wdata,
    input  logic [NUM_PE*4-1:0]    i_pe_wstrb,
    output logic [NUM_PE-1:0]      o_pe_gnt,
    output logic [NUM_PE-1:0]      o_pe_ready,
    output logic [NUM_PE*32-1:0]   o_pe_rdata,
    output logic                   o_bus_rden,
    output logic                   o_bus_wren,
    output logic [31:0]            o_bus_addr,
    output logic [31:0]            o_bus_wdata,
    output logic [3:0]             o_bus_wstrb,
    input  logic [31:0]            i_bus_rdata,
    input  logic                   i_bus_ready,
    output logic                   o_timeout
);

    localparam int              IDW      = pe_id_w(NUM_PE);
    localparam int              CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [IDW-1:0]  ID_LAST  = IDW'(NUM_PE - 1);

    arb_state_t             state_q, state_d;
    logic [IDW-1:0]         last_gnt_q;
    logic [IDW-1:0]         id_q;
    logic                   we_q;
    logic                   to_q;
    logic [CW-1:0]          cnt_q;
    logic [31:0]            addr_q, wdata_q;
    logic [3:0]             wstrb_q;
    logic [NUM_PE*32-1:0]   rdata_q;

    logic [NUM_PE-1:0]      arb_gnt;
    logic [IDW-1:0]         arb_id;
    logic                   arb_vld;

    logic                   take;
    logic                   cap_bus;
    logic                   cap_err;

    rr_arbiter #(.NUM_PE(NUM_PE)) u_rr (
        .req      (i_pe_rden | i_pe_wren),
        .last_gnt (last_gnt_q),
        .gnt      (arb_gnt),
        .gnt_id   (arb_id),
        .gnt_vld  (arb_vld)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        cap_bus = 1'b0;
        cap_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    take    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Combinational slaves answer in the strobe cycle itself.
                if (i_bus_ready) begin
                    cap_bus = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Ready has priority over a timeout landing in the same cycle.
                if (i_bus_ready) begin
                    cap_bus = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cap_err = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_gnt_q <= ID_LAST;
            id_q       <= '0;
            we_q       <= 1'b0;
            to_q       <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
        end else begin
            if (take) begin
                addr_q  <= i_pe_addr[{arb_id, 5'b0} +: 32];
                wdata_q <= i_pe_wdata[{arb_id, 5'b0} +: 32];
                wstrb_q <= i_pe_wstrb[{arb_id, 2'b0} +: 4];
                // Write wins when a PE raises both strobes.
                we_q    <= i_pe_wren[arb_id];
                id_q    <= arb_id;
            end
            if (state_q == ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == WAIT && cnt_q != '1) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (cap_bus) begin
                rdata_q[{id_q, 5'b0} +: 32] <= i_bus_rdata;
                to_q                        <= 1'b0;
            end else if (cap_err) begin
                rdata_q[{id_q, 5'b0} +: 32] <= ERR_RDATA;
                to_q                        <= 1'b1;
            end
            if (state_q == RESP) begin
                last_gnt_q <= id_q;
            end
        end
    end

    always_comb begin
        o_pe_ready = '0;
        if (state_q == RESP) begin
            o_pe_ready[id_q] = 1'b1;
        end
    end

    assign o_pe_gnt    = (state_q == IDLE) ? arb_gnt : '0;
    assign o_pe_rdata  = rdata_q;
    assign o_bus_rden  = (state_q == ISSUE) && !we_q;
    assign o_bus_wren  = (state_q == ISSUE) &&  we_q;
    assign o_bus_addr  = addr_q;
    assign o_bus_wdata = wdata_q;
    assign o_bus_wstrb = wstrb_q;
    assign o_timeout   = (state_q == RESP) && to_q;

endmodule

// File: tb/tb_peri_bus_arbiter.sv
// Directed plus randomized checks of peri_bus_arbiter against a transaction-level model.
// Latency: model predicts response cycle as strobe + min(delay, TO) + 1.
// Backpressure: bench PEs hold requests until granted, then drop them.
module tb_peri_bus_arbiter;

    localparam int NPE = 3;
    localparam int TO  = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic              clk = 1'b0;
    logic              rst;
    logic [NPE-1:0]    rden, wren;
    logic [NPE*32-1:0] addr, wdata;
    logic [NPE*4-1:0]  wstrb;
    logic [31:0]       bus_rdata;
    logic              bus_ready;

    logic [NPE-1:0]    pe_gnt, pe_ready;
    logic [NPE*32-1:0] pe_rdata;
    logic              bus_rden, bus_wren, timeout;
    logic [31:0]       bus_addr, bus_wdata;
    logic [3:0]        bus_wstrb;

    int          checks = 0;
    int          errors = 0;
    int          last_gnt;
    logic [31:0] model_rdata [NPE];

    peri_bus_arbiter #(.NUM_PE(NPE), .TIMEOUT_CYC(TO), .ERR_RDATA(ERR)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_pe_rden   (rden),
        .i_pe_wren   (wren),
        .i_pe_addr   (addr),
        .i_pe_wdata  (wdata),
        .i_pe_wstrb  (wstrb),
        .o_pe_gnt    (pe_gnt),
        .o_pe_ready  (pe_ready),
        .o_pe_rdata  (pe_rdata),
        .o_bus_rden  (bus_rden),
        .o_bus_wren  (bus_wren),
        .o_bus_addr  (bus_addr),
        .o_bus_wdata (bus_wdata),
        .o_bus_wstrb (bus_wstrb),
        .i_bus_rdata (bus_rdata),
        .i_bus_ready (bus_ready),
        .o_timeout   (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_rdata(input string tag);
        for (int k = 0; k < NPE; k++) begin
            chk($sformatf("%s_rdata%0d", tag, k), pe_rdata[k*32 +: 32], model_rdata[k]);
        end
    endtask

    task automatic set_req(input int k, input int mode);
        rden[k] = (mode != 1);
        wren[k] = (mode != 0);
        addr[k*32 +: 32]  = $urandom;
        wdata[k*32 +: 32] = $urandom;
        wstrb[k*4 +: 4]   = 4'($urandom_range(0, 15));
    endtask

    // Entered in an IDLE cycle with requests already driven; returns at the
    // sample point of the RESP cycle. d = cycles after the strobe cycle at
    // which the slave answers (0 = combinational, > TO = never in time).
    task automatic serve(input int d, input logic [31:0] sdata);
        logic [NPE-1:0] req;
        int             w;
        logic           we;
        logic [31:0]    ea, ewd;
        logic [3:0]     ews;
        int             r;
        logic [31:0]    exp_data;
        #1;
        req = rden | wren;
        w = -1;
        for (int i = 0; i < NPE; i++) begin
            int k;
            k = (last_gnt + 1 + i) % NPE;
            if (w < 0 && req[k]) w = k;
        end
        if (w < 0) begin
            $display("FAIL serve_setup: no requester driven");
            $fatal(1, "bench setup");
        end
        chk("gnt", 32'(pe_gnt), 32'(1) << w);
        chk("ready_idle", 32'(pe_ready), 32'd0);
        we  = wren[w];
        ea  = addr[w*32 +: 32];
        ewd = wdata[w*32 +: 32];
        ews = wstrb[w*4 +: 4];
        r   = ((d > TO) ? TO : d) + 1;
        exp_data = (d > TO) ? ERR : sdata;

        // Strobe cycle; the winner drops its request and scribbles its inputs.
        tick();
        rden[w] = 1'b0;
        wren[w] = 1'b0;
        addr[w*32 +: 32]  = $urandom;
        wdata[w*32 +: 32] = $urandom;
        wstrb[w*4 +: 4]   = 4'($urandom_range(0, 15));
        bus_ready = (d == 0);
        bus_rdata = (d == 0) ? sdata : $urandom;
        #1;
        chk("issue_rden", 32'(bus_rden), 32'(!we));
        chk("issue_wren", 32'(bus_wren), 32'(we));
        chk("issue_addr", bus_addr, ea);
        chk("issue_wdata", bus_wdata, ewd);
        chk("issue_wstrb", 32'(bus_wstrb), 32'(ews));
        chk("issue_gnt", 32'(pe_gnt), 32'd0);
        chk("issue_ready", 32'(pe_ready), 32'd0);

        for (int c = 1; c <= r; c++) begin
            tick();
            bus_ready = (c == d) ? 1'b1 : ((c == r) ? 1'($urandom_range(0, 1)) : 1'b0);
            bus_rdata = (c == d) ? sdata : $urandom;
            #1;
            chk("strobe_rd_idle", 32'(bus_rden), 32'd0);
            chk("strobe_wr_idle", 32'(bus_wren), 32'd0);
            chk("hold_addr", bus_addr, ea);
            chk("hold_wdata", bus_wdata, ewd);
            chk("busy_gnt", 32'(pe_gnt), 32'd0);
            if (c == r) begin
                model_rdata[w] = exp_data;
                chk("resp_ready", 32'(pe_ready), 32'(1) << w);
                chk("resp_timeout", 32'(timeout), 32'(d > TO));
                chk_all_rdata("resp");
            end else begin
                chk("wait_ready", 32'(pe_ready), 32'd0);
                chk("wait_timeout", 32'(timeout), 32'd0);
            end
        end
        last_gnt = w;
    endtask

    initial begin
        rst = 1'b1;
        rden = '0; wren = '0; addr = '0; wdata = '0; wstrb = '0;
        bus_rdata = '0; bus_ready = 1'b0;
        last_gnt = NPE - 1;
        for (int k = 0; k < NPE; k++) model_rdata[k] = '0;

        // Reset values.
        tick();
        tick();
        chk("rst_gnt", 32'(pe_gnt), 32'd0);
        chk("rst_ready", 32'(pe_ready), 32'd0);
        chk("rst_rden", 32'(bus_rden), 32'd0);
        chk("rst_wren", 32'(bus_wren), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk_all_rdata("rst");
        rst = 1'b0;

        // All three PEs write from reset: served 0,1,2, then PE0 again.
        tick();
        for (int k = 0; k < NPE; k++) set_req(k, 1);
        serve(1, 32'hA000_0000);
        tick(); serve(1, 32'hA000_0001);
        tick(); serve(1, 32'hA000_0002);
        tick(); set_req(0, 1); serve(1, 32'hA000_0003);

        // Single read from PE1, slave answers 3 cycles after the strobe.
        tick();
        rden[1] = 1'b1;
        addr[32 +: 32] = 32'h1000_0010;
        serve(3, 32'h1234_5678);
        chk("single_rdata1", pe_rdata[32 +: 32], 32'h1234_5678);

        // last_gnt = 1: PE0 and PE2 together, PE2 first then PE0.
        tick();
        set_req(0, 0);
        set_req(2, 1);
        serve(2, 32'hB0B0_0002);
        tick(); serve(2, 32'hB0B0_0000);

        // Dead slave: forced completion, then stray ready in IDLE ignored.
        tick();
        set_req(2, 0);
        serve(TO + 12, 32'h1111_1111);
        for (int i = 0; i < 2; i++) begin
            tick();
            bus_ready = 1'b1;
            #1;
            chk("stray_gnt", 32'(pe_gnt), 32'd0);
            chk("stray_ready", 32'(pe_ready), 32'd0);
            chk("stray_rden", 32'(bus_rden), 32'd0);
            chk("stray_timeout", 32'(timeout), 32'd0);
            chk_all_rdata("stray");
        end

        // Combinational slave, then ready on the exact timeout cycle.
        tick();
        bus_ready = 1'b0;
        set_req(1, 0);
        serve(0, 32'hC0FF_EE01);
        tick();
        set_req(0, 1);
        serve(TO, 32'h5A5A_5A5A);

        // Reset in the middle of a wait: abandoned, outputs cleared.
        tick();
        bus_ready = 1'b0;
        set_req(2, 0);
        #1;
        chk("abort_gnt", 32'(pe_gnt), 32'd4);
        tick();
        rden[2] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        last_gnt = NPE - 1;
        for (int k = 0; k < NPE; k++) model_rdata[k] = '0;
        chk("abort_ready", 32'(pe_ready), 32'd0);
        chk("abort_rden", 32'(bus_rden), 32'd0);
        chk("abort_addr", bus_addr, 32'd0);
        chk("abort_wstrb", 32'(bus_wstrb), 32'd0);
        chk("abort_timeout", 32'(timeout), 32'd0);
        chk_all_rdata("abort");
        tick();
        set_req(0, 0);
        set_req(1, 2);
        serve(2, 32'hD000_0000);
        tick(); serve(4, 32'hD000_0001);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            tick();
            for (int k = 0; k < NPE; k++) begin
                if (!(rden[k] | wren[k]) && $urandom_range(0, 1) == 1) begin
                    set_req(k, $urandom_range(0, 2));
                end
            end
            if ((rden | wren) == '0) set_req($urandom_range(0, NPE - 1), $urandom_range(0, 2));
            bus_ready = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
            serve($urandom_range(0, TO + 3), $urandom);
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
